// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants, data-position table and encoder state type.
// HAMMING_SECDED_EN widens the codeword by one overall-parity bit.
package hamming_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 15;
    localparam int unsigned PAR_W  = 4;
    localparam int unsigned IDX_W  = 4;

`ifdef HAMMING_SECDED_EN
    localparam int unsigned OUT_W = CODE_W + 1;
`else
    localparam int unsigned OUT_W = CODE_W;
`endif

    // 1-based codeword position of data bit d1..d11
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/hamming_parity_15_11.sv
// Combinational Hamming(15,11) builder: scatters data to its positions and fills
// the even-parity bits at positions 1,2,4,8. Shared with the decoder syndrome check.
module hamming_parity_15_11
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] codeword_c
);

    logic [CODE_W-1:0] data_word;
    logic [PAR_W-1:0]  parity;

    always_comb begin
        data_word = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            data_word[4'(DATA_POS[i] - 1)] = data_in[4'(i)];
        end
    end

    // Parity positions are still zero in data_word, so each check covers all positions with bit k set
    always_comb begin
        parity = '0;
        for (int k = 0; k < int'(PAR_W); k++) begin
            for (int j = 1; j <= int'(CODE_W); j++) begin
                if (((j >> k) & 1) == 1) begin
                    parity[2'(k)] = parity[2'(k)] ^ data_word[4'(j - 1)];
                end
            end
        end
    end

    always_comb begin
        codeword_c = data_word;
        for (int k = 0; k < int'(PAR_W); k++) begin
            codeword_c[4'((1 << k) - 1)] = parity[2'(k)];
        end
    end

endmodule

// File: rtl/hamming_encoder_15_11.sv
// Hamming(15,11) encoder: accepts an 11-bit word, serialises the codeword LSB-first on a
// valid/ready stream, then idles GAP_CYCLES. HAMMING_SECDED_EN appends overall parity p0.
module hamming_encoder_15_11
    import hamming_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [OUT_W-1:0]  codeword
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : IDX_W'(GAP_CYCLES - 1);

    logic [CODE_W-1:0] enc_c;
    logic [OUT_W-1:0]  enc_word;

    hamming_parity_15_11 u_parity (
        .data_in    (data_in),
        .codeword_c (enc_c)
    );

`ifdef HAMMING_SECDED_EN
    assign enc_word = {^enc_c, enc_c};
`else
    assign enc_word = enc_c;
`endif

    enc_state_e       state, state_d;
    logic [IDX_W-1:0] idx, idx_d, idx_inc;
    logic [IDX_W-1:0] gap_cnt, gap_cnt_d;
    logic [OUT_W-1:0] codeword_d;
    logic             in_ready_d, ser_out_d, ser_valid_d, ser_last_d;

    // Next-state and next-output logic; every register holds unless updated
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        gap_cnt_d   = gap_cnt;
        codeword_d  = codeword;
        in_ready_d  = in_ready;
        ser_out_d   = ser_out;
        ser_valid_d = ser_valid;
        ser_last_d  = ser_last;
        idx_inc     = idx + IDX_W'(1);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    codeword_d  = enc_word;
                    in_ready_d  = 1'b0;
                    ser_valid_d = 1'b1;
                    ser_out_d   = enc_word[0];
                    ser_last_d  = (LAST_IDX == '0);
                end
            end
            SEND: begin
                if (ser_valid && ser_ready) begin
                    if (idx == LAST_IDX) begin
                        ser_valid_d = 1'b0;
                        ser_last_d  = 1'b0;
                        ser_out_d   = 1'b0;
                        gap_cnt_d   = '0;
                        if (GAP_CYCLES == 0) begin
                            state_d    = IDLE;
                            in_ready_d = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        idx_d      = idx_inc;
                        ser_out_d  = codeword[idx_inc];
                        ser_last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt + IDX_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                ser_valid_d = 1'b0;
                ser_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            codeword  <= '0;
            in_ready  <= 1'b1;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            gap_cnt   <= gap_cnt_d;
            codeword  <= codeword_d;
            in_ready  <= in_ready_d;
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            ser_last  <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_hamming_encoder_15_11.sv
// Directed self-checking bench for hamming_encoder_15_11 (GAP_CYCLES=3 and 0 instances).
module tb_hamming_encoder_15_11;

    localparam int unsigned GAP = 3;
`ifdef HAMMING_SECDED_EN
    localparam int unsigned N = 16;
    localparam logic [15:0] CW_000 = 16'h0000;
    localparam logic [15:0] CW_001 = 16'h8007;
    localparam logic [15:0] CW_400 = 16'hC08B;
    localparam logic [15:0] CW_7FF = 16'hFFFF;
`else
    localparam int unsigned N = 15;
    localparam logic [14:0] CW_000 = 15'h0000;
    localparam logic [14:0] CW_001 = 15'h0007;
    localparam logic [14:0] CW_400 = 15'h408B;
    localparam logic [14:0] CW_7FF = 15'h7FFF;
`endif

    logic          clk;
    logic          reset;
    logic [10:0]   data_in;
    logic          in_valid, in_ready, ser_out, ser_valid, ser_ready, ser_last;
    logic [N-1:0]  codeword;
    logic [10:0]   z_data_in;
    logic          z_in_valid, z_in_ready, z_ser_out, z_ser_valid, z_ser_ready, z_ser_last;
    logic [N-1:0]  z_codeword;

    int tests = 0;
    int fails = 0;

    hamming_encoder_15_11 #(.GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
        .codeword(codeword)
    );

    hamming_encoder_15_11 #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .data_in(z_data_in), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .ser_out(z_ser_out), .ser_valid(z_ser_valid), .ser_ready(z_ser_ready), .ser_last(z_ser_last),
        .codeword(z_codeword)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word and wait (bounded) until the DUT takes it; returns at the next negedge
    task automatic accept_word(input logic [10:0] d);
        int n;
        n = 0;
        data_in  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect one frame with ser_ready high, optionally stalling 4 cycles at bit stall_at
    task automatic recv_frame(input string tag, input logic [N-1:0] exp_cw, input int stall_at);
        logic [N-1:0] rx;
        int hs, last_at, cyc;
        bit stalled;
        rx = '0; hs = 0; last_at = -1; cyc = 0; stalled = 0;
        chk({tag, "_latency"}, 32'(ser_valid), 1);
        ser_ready = 1'b1;
        while (hs < int'(N) && cyc < 200) begin
            if (stall_at >= 0 && hs == stall_at && !stalled) begin
                stalled   = 1;
                ser_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    cyc++;
                    chk({tag, "_stall_out"}, 32'(ser_out), 32'(exp_cw[stall_at]));
                    chk({tag, "_stall_valid"}, 32'(ser_valid), 1);
                end
                ser_ready = 1'b1;
            end
            if (ser_valid && ser_ready) begin
                rx[hs] = ser_out;
                if (ser_last) last_at = hs;
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_bits"}, 32'(rx), 32'(exp_cw));
        chk({tag, "_handshakes"}, 32'(hs), N);
        chk({tag, "_last_pos"}, 32'(last_at), N - 1);
        chk({tag, "_codeword"}, 32'(codeword), 32'(exp_cw));
        chk({tag, "_valid_after"}, 32'(ser_valid), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0; data_in = '0; in_valid = 1'b0; ser_ready = 1'b0;
        z_data_in = '0; z_in_valid = 1'b0; z_ser_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ser_valid), 0);
        chk("rst_last", 32'(ser_last), 0);
        chk("rst_codeword", 32'(codeword), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // All-zero, single-bit and all-ones words
        accept_word(11'h000);
        recv_frame("w000", CW_000, -1);
        accept_word(11'h001);
        recv_frame("w001", CW_001, -1);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("hold_codeword", 32'(codeword), 32'(CW_001));
        accept_word(11'h7FF);
        recv_frame("w7ff", CW_7FF, -1);

        // Stall at index 6: bit 6 of 0x408B is 0 and bit 7 is 1, so an early advance shows
        accept_word(11'h400);
        recv_frame("w400_stall", CW_400, 6);

        // Back-to-back with a held in_valid: second word ignored during SEND, taken after GAP
        accept_word(11'h7FF);
        data_in  = 11'h001;
        in_valid = 1'b1;
        recv_frame("b2b_first", CW_7FF, -1);
        chk("gap_in_ready_low", 32'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("gap_len", 32'(n), GAP);
        @(negedge clk);
        in_valid = 1'b0;
        recv_frame("b2b_second", CW_001, -1);

        // Reset mid-frame after 5 bits
        accept_word(11'h7FF);
        ser_ready = 1'b1;
        n = 0;
        while (n < 5) begin
            if (ser_valid) n++;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ser_valid), 0);
        chk("mid_rst_out", 32'(ser_out), 0);
        chk("mid_rst_codeword", 32'(codeword), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_codeword", 32'(codeword), 0);
        repeat (3) @(negedge clk);
        chk("post_rst_no_resume", 32'(ser_valid), 0);
        ser_ready = 1'b0;

        // GAP_CYCLES=0 instance returns to IDLE right after the last handshake
        z_data_in = 11'h001; z_in_valid = 1'b1; z_ser_ready = 1'b1;
        @(negedge clk);
        z_in_valid = 1'b0;
        chk("g0_latency", 32'(z_ser_valid), 1);
        n = 0;
        while (!(z_ser_valid && z_ser_last) && n < 40) begin @(negedge clk); n++; end
        chk("g0_last_pos", 32'(n), N - 1);
        @(negedge clk);
        chk("g0_ready_back", 32'(z_in_ready), 1);
        chk("g0_valid_low", 32'(z_ser_valid), 0);
        chk("g0_codeword", 32'(z_codeword), 32'(CW_001));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamming_encoder_15_11.md
Name: hamming_encoder_15_11

Overview:
- Downstream stage of the 11-bit data-collection shifter in the Hamming transmit path.
- Accepts one 11-bit data word in parallel once the shifter holds a complete word.
- Computes the four Hamming(15,11) parity bits and builds the 15-bit codeword.
- Serialises the codeword one bit per accepted cycle onto a valid/ready stream toward the channel, and also holds the codeword on a parallel output for debug.

Parameters:
- GAP_CYCLES, 0, number of idle cycles inserted after the last serial bit before in_ready rises again (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- data_in  input  11  data word; data_in[0] = d1 (first bit shifted into the collector), data_in[10] = d11.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block can accept a word (IDLE state only).
- ser_out  output  1  current codeword bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- ser_last  output  1  ser_out is the final bit of the codeword.
- codeword  output  15 (16 with HAMMING_SECDED_EN)  latched codeword; bit i-1 = position i.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, bit index=0, codeword=0, ser_out=0, ser_valid=0, ser_last=0, in_ready=1 once reset releases.
  - Reset mid-frame aborts the frame; no partial bits resume.
- Position map:
  - Data d1..d11 go to positions 3,5,6,7,9,10,11,12,13,14,15.
  - Parity goes to positions 1,2,4,8.
- Parity (even):
  - p1 = XOR of positions 3,5,7,9,11,13,15.
  - p2 = XOR of positions 3,6,7,10,11,14,15.
  - p4 = XOR of positions 5,6,7,12,13,14,15.
  - p8 = XOR of positions 9..15.
- FSM states IDLE, SEND, GAP:
  - IDLE: in_ready=1. When in_valid=1, latch the encoded word into codeword, set index=0, go to SEND on the next edge. Latency is 1 cycle from accept to the first ser_valid.
  - SEND: ser_valid=1 and ser_out=codeword[index]; position 1 goes first. On ser_valid&ser_ready, index increments. Without the handshake, ser_out and index hold, and ser_out stays stable while stalled.
  - SEND, last bit: ser_last=1 when index = N-1 (N=15, or 16 with SECDED). On handshake of the last bit, go to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - GAP: counter counts GAP_CYCLES cycles, then the block goes to IDLE. ser_valid=0 and in_ready=0 throughout GAP.
- in_valid in SEND or GAP is ignored and no word is captured; upstream must hold in_valid.
- Minimum period with no stalls: 1 + N + GAP_CYCLES cycles per word.
- codeword holds its value until the next accept; it is not cleared when a frame ends.
- Index counter is 4 bits wide; it never wraps within a frame and resets to 0 on each accept.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
  - Defined: adds an overall parity bit p0 = XOR of all 15 positions at codeword[15]. That bit is sent last (N=16, ser_last on it), and codeword is 16 bits wide.
  - Undefined: pure Hamming(15,11), N=15, codeword is 15 bits wide.

Decomposition:
- Shared package hamming_pkg holds:
  - constants DATA_W=11, CODE_W=15, PAR_W=4;
  - the data-position table;
  - the state enum type (IDLE/SEND/GAP).
- One natural combinational sub-module, hamming_parity_15_11: data_in in, 15-bit codeword out. It is reused later by the decoder's syndrome check.

Test Plan:
- Pulse reset low mid-SEND after 5 bits → outputs clear immediately; after release, in_ready=1, ser_valid=0, codeword=0.
- data_in=11'h000 → codeword=15'h0000; 15 serial zeros; ser_last on the 15th bit.
- data_in=11'h001 → codeword=15'h0007; serial bits 1,1,1 then 12 zeros.
- data_in=11'h400 → codeword=15'h408B; data_in=11'h7FF → codeword=15'h7FFF.
- Hold ser_ready=0 for 4 cycles at index 6 → ser_out and index frozen; the frame completes with exactly 15 handshakes.
- GAP_CYCLES=3, back-to-back in_valid → second word accepted exactly 3 cycles after the last-bit handshake, and in_valid during SEND is ignored. SECDED build with 11'h001 → codeword=16'h8007, wait no: p0 = XOR of 3 ones = 1, so codeword=16'h8007 and 16 bits are sent.
